// File: rtl/load_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_hazard_unit
// Brief    : LOAD_LAT-deep in-flight load tracker with load-use stall detect,
//            memory-wait freeze, flush and optional writeback forwarding.
// Revision : 1.0  initial release
// ============================================================================
module load_hazard_unit #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 2,
    parameter int FWD      = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              issue_valid,
    input  logic                              issue_load,
    input  logic [REG_AW-1:0]                 issue_rd,
    input  logic [XLEN-1:0]                   issue_addr,
    input  logic [REG_AW-1:0]                 dec_rs1,
    input  logic                              dec_rs1_used,
    input  logic [REG_AW-1:0]                 dec_rs2,
    input  logic                              dec_rs2_used,
    input  logic                              mem_ready,
    input  logic                              flush,
    output logic                              delayed_load,
    output logic [REG_AW-1:0]                 delayed_rd,
    output logic [XLEN-1:0]                   delayed_addr,
    output logic                              wb_valid,
    output logic                              stall,
    output logic                              mem_wait,
    output logic [$clog2(LOAD_LAT+1)-1:0]     pending_cnt
);

    localparam int c_HEAD = LOAD_LAT - 1;
    localparam int c_CW   = $clog2(LOAD_LAT + 1);

    logic [LOAD_LAT-1:0] r_valid;
    logic [REG_AW-1:0]   r_rd   [LOAD_LAT];
    logic [XLEN-1:0]     r_addr [LOAD_LAT];
    logic [c_CW-1:0]     r_cnt;

    logic [LOAD_LAT-1:0] w_valid_nxt;
    logic [c_CW-1:0]     w_cnt_nxt;
    logic                w_mem_wait;
    logic                w_advance;
    logic                w_accept;
    logic                w_hazard;

    function automatic logic f_match(
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs1,
        input logic              rs1_used,
        input logic [REG_AW-1:0] rs2,
        input logic              rs2_used
    );
        return (rd != '0) && ((rs1_used && (rd == rs1)) || (rs2_used && (rd == rs2)));
    endfunction

    assign w_mem_wait = r_valid[c_HEAD] & ~mem_ready;
    assign w_advance  = ~w_mem_wait;
    assign w_accept   = issue_valid & issue_load & w_advance & ~flush;

    // The head is already issued to memory, so a flush never drops it while it waits.
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_advance) begin
            w_valid_nxt[0] = w_accept;
            for (int i = 1; i < LOAD_LAT; i++) begin
                w_valid_nxt[i] = r_valid[i-1] & ~flush;
            end
        end else if (flush) begin
            for (int i = 0; i < LOAD_LAT - 1; i++) begin
                w_valid_nxt[i] = 1'b0;
            end
        end
        w_cnt_nxt = '0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            w_cnt_nxt = w_cnt_nxt + c_CW'(w_valid_nxt[i]);
        end
    end

    always_comb begin
        w_hazard = 1'b0;
        if (issue_valid && issue_load &&
            f_match(issue_rd, dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used)) begin
            w_hazard = 1'b1;
        end
        for (int i = 0; i < LOAD_LAT - 1; i++) begin
            if (r_valid[i] && f_match(r_rd[i], dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used)) begin
                w_hazard = 1'b1;
            end
        end
        if (r_valid[c_HEAD] && !((FWD != 0) && mem_ready) &&
            f_match(r_rd[c_HEAD], dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used)) begin
            w_hazard = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < LOAD_LAT; i++) begin
                r_rd[i]   <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_advance) begin
                r_rd[0]   <= issue_rd;
                r_addr[0] <= issue_addr;
                for (int i = 1; i < LOAD_LAT; i++) begin
                    r_rd[i]   <= r_rd[i-1];
                    r_addr[i] <= r_addr[i-1];
                end
            end
        end
    end

    assign delayed_load = r_valid[c_HEAD];
    assign delayed_rd   = r_rd[c_HEAD];
    assign delayed_addr = r_addr[c_HEAD];
    assign pending_cnt  = r_cnt;
    assign mem_wait     = w_mem_wait;
    assign wb_valid     = r_valid[c_HEAD] & mem_ready;
    // The execute-stage candidate is not a register, so gate it during reset.
    assign stall        = rst & (w_hazard | w_mem_wait);

endmodule
`default_nettype wire

// File: tb/tb_load_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_hazard_unit
// Brief    : Randomized + directed bench for load_hazard_unit, two parameter
//            sets compared against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_load_hazard_unit;

    logic        clk;
    logic        rst;
    logic        issue_valid, issue_load;
    logic [4:0]  issue_rd;
    logic [31:0] issue_addr;
    logic [4:0]  dec_rs1, dec_rs2;
    logic        dec_rs1_used, dec_rs2_used;
    logic        mem_ready, flush;

    logic        a_load, a_wb, a_stall, a_mw;
    logic [4:0]  a_rd;
    logic [31:0] a_addr;
    logic [1:0]  a_cnt;
    logic        b_load, b_wb, b_stall, b_mw;
    logic [4:0]  b_rd;
    logic [31:0] b_addr;
    logic [1:0]  b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    load_hazard_unit #(.XLEN(32), .REG_AW(5), .LOAD_LAT(2), .FWD(1)) u_dut_a (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_load(issue_load),
        .issue_rd(issue_rd), .issue_addr(issue_addr), .dec_rs1(dec_rs1),
        .dec_rs1_used(dec_rs1_used), .dec_rs2(dec_rs2), .dec_rs2_used(dec_rs2_used),
        .mem_ready(mem_ready), .flush(flush), .delayed_load(a_load), .delayed_rd(a_rd),
        .delayed_addr(a_addr), .wb_valid(a_wb), .stall(a_stall), .mem_wait(a_mw),
        .pending_cnt(a_cnt)
    );

    load_hazard_unit #(.XLEN(32), .REG_AW(5), .LOAD_LAT(3), .FWD(0)) u_dut_b (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_load(issue_load),
        .issue_rd(issue_rd), .issue_addr(issue_addr), .dec_rs1(dec_rs1),
        .dec_rs1_used(dec_rs1_used), .dec_rs2(dec_rs2), .dec_rs2_used(dec_rs2_used),
        .mem_ready(mem_ready), .flush(flush), .delayed_load(b_load), .delayed_rd(b_rd),
        .delayed_addr(b_addr), .wb_valid(b_wb), .stall(b_stall), .mem_wait(b_mw),
        .pending_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] addr;
    } slot_t;
    typedef slot_t slotq_t[$];

    // Index 0 is the oldest load (the one presented to memory).
    slotq_t qa, qb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic slotq_t fresh_q(input int lat);
        slotq_t q;
        for (int i = 0; i < lat; i++) q.push_back('0);
        return q;
    endfunction

    function automatic slotq_t next_q(input slotq_t q);
        slotq_t n;
        slot_t  s;
        n = q;
        if (n[0].v && !mem_ready) begin
            for (int i = 1; i < n.size(); i++) if (flush) n[i].v = 1'b0;
        end else begin
            void'(n.pop_front());
            for (int i = 0; i < n.size(); i++) if (flush) n[i].v = 1'b0;
            s.v    = issue_valid & issue_load & ~flush;
            s.rd   = issue_rd;
            s.addr = issue_addr;
            n.push_back(s);
        end
        return n;
    endfunction

    function automatic bit reads_reg(input logic [4:0] rd);
        return rd != 0 && ((dec_rs1_used && rd == dec_rs1) || (dec_rs2_used && rd == dec_rs2));
    endfunction

    task automatic check_inst(input string nm, input slotq_t q, input bit fwd,
                              input logic dl, input logic [4:0] drd, input logic [31:0] daddr,
                              input logic wb, input logic st, input logic mw, input logic [1:0] cnt);
        bit haz, e_mw;
        int pend;
        e_mw = q[0].v && !mem_ready;
        haz  = issue_valid && issue_load && reads_reg(issue_rd);
        pend = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].v) pend++;
            if (q[i].v && reads_reg(q[i].rd) && !(i == 0 && fwd && mem_ready)) haz = 1;
        end
        check({nm, "_dload"}, 64'(dl), 64'(q[0].v));
        check({nm, "_drd"}, 64'(drd), 64'(q[0].rd));
        check({nm, "_daddr"}, 64'(daddr), 64'(q[0].addr));
        check({nm, "_wb"}, 64'(wb), 64'(q[0].v && mem_ready));
        check({nm, "_mwait"}, 64'(mw), 64'(e_mw));
        check({nm, "_stall"}, 64'(st), 64'(haz || e_mw));
        check({nm, "_pcnt"}, 64'(cnt), 64'(pend));
    endtask

    task automatic tick();
        @(negedge clk);
        check_inst("A", qa, 1'b1, a_load, a_rd, a_addr, a_wb, a_stall, a_mw, a_cnt);
        check_inst("B", qb, 1'b0, b_load, b_rd, b_addr, b_wb, b_stall, b_mw, b_cnt);
        @(posedge clk);
        qa = next_q(qa);
        qb = next_q(qb);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic mr, input logic fl);
        issue_valid = iv; issue_load = iv; issue_rd = rd; issue_addr = addr;
        dec_rs1 = rs1; dec_rs1_used = u1; dec_rs2 = rs2; dec_rs2_used = u2;
        mem_ready = mr; flush = fl;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_zero_a"}, {a_load, a_rd, a_addr, a_wb, a_stall, a_mw, a_cnt}, '0);
        check({tag, "_zero_b"}, {b_load, b_rd, b_addr, b_wb, b_stall, b_mw, b_cnt}, '0);
    endtask

    initial begin
        rst = 1'b0;
        drive(1, 5'd3, 32'h40, 5'd3, 1, 0, 0, 1, 0);
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        qa = fresh_q(2);
        qb = fresh_q(3);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();

        // Load x5 then consume it in decode
        drive(1, 5'd5, 32'h100, 5'd5, 1, 0, 0, 1, 0);
        tick();
        drive(0, 5'd0, 32'h0, 5'd5, 1, 0, 0, 1, 0);
        tick();
        check("tp1_rd", 64'(a_rd), 64'd5);
        check("tp1_addr", 64'(a_addr), 64'h100);
        check("tp1_wb", 64'(a_wb), 64'd1);
        check("tp1_stall_fwd", 64'(a_stall), 64'd0);
        repeat (3) tick();

        // Load to x0 never hazards
        drive(1, 5'd0, 32'h80, 5'd0, 1, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 5'd0, 1, 0, 0, 1, 0);
        repeat (4) tick();

        // Memory wait with an issue attempt during the wait
        drive(1, 5'd7, 32'h200, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 5'd9, 32'h300, 5'd9, 1, 0, 0, 0, 0);
        repeat (3) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (4) tick();

        // Back-to-back loads, decode reads x4 via rs2
        drive(1, 5'd3, 32'h10, 0, 0, 5'd4, 1, 1, 0);
        tick();
        drive(1, 5'd4, 32'h14, 0, 0, 5'd4, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 5'd4, 1, 1, 0);
        repeat (4) tick();

        // Flush while the head waits on memory
        drive(1, 5'd1, 32'h500, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 5'd2, 32'h504, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (4) tick();

        // Asynchronous reset mid-wait with loads pending
        drive(1, 5'd6, 32'h600, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 5'd8, 32'h604, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 5'd8, 32'h608, 5'd8, 1, 0, 0, 0, 0);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        rst = 1'b1;
        qa = fresh_q(2);
        qb = fresh_q(3);
        repeat (4) tick();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            issue_valid  = ($urandom_range(0, 9) < 7);
            issue_load   = ($urandom_range(0, 9) < 6);
            issue_rd     = 5'($urandom_range(0, 7));
            issue_addr   = $urandom;
            dec_rs1      = 5'($urandom_range(0, 7));
            dec_rs2      = 5'($urandom_range(0, 7));
            dec_rs1_used = 1'($urandom_range(0, 1));
            dec_rs2_used = 1'($urandom_range(0, 1));
            mem_ready    = ($urandom_range(0, 9) < 7);
            flush        = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_hazard_unit.md
Name: load_hazard_unit

Overview:
Parametrised successor to the single-cycle load delay register in the integer pipeline.
- Tracks in-flight loads through a LOAD_LAT-deep slot pipeline and presents the oldest load (rd, address, valid) to the memory/writeback stage.
- Detects load-use hazards against the decode-stage instruction and raises stall.
- Freezes on a memory-wait handshake (mem_ready).
- Supports pipeline flush and an optional writeback-forwarding mode.

Parameters:
XLEN, 32, address width
REG_AW, 5, register index width
LOAD_LAT, 2, number of slots (cycles from issue to head); legal range 1..8
FWD, 1, 1 = head slot with mem_ready high creates no hazard (data forwarded); 0 = head always hazards

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active low
issue_valid  in  1  execute-stage instruction valid
issue_load  in  1  execute-stage instruction is a load
issue_rd  in  REG_AW  load destination register
issue_addr  in  XLEN  load effective address (ALU output)
dec_rs1  in  REG_AW  decode-stage source 1
dec_rs1_used  in  1  source 1 is read
dec_rs2  in  REG_AW  decode-stage source 2
dec_rs2_used  in  1  source 2 is read
mem_ready  in  1  memory returns data for the head slot this cycle
flush  in  1  discard loads not yet at head
delayed_load  out  1  head slot valid
delayed_rd  out  REG_AW  head slot rd
delayed_addr  out  XLEN  head slot address
wb_valid  out  1  head load completes this cycle
stall  out  1  hold decode/fetch
mem_wait  out  1  head waiting on memory
pending_cnt  out  clog2(LOAD_LAT+1)  number of valid slots

Behaviour:
- Slots 0..LOAD_LAT-1 each hold {valid, rd, addr}. Slot LOAD_LAT-1 is the head and drives delayed_load, delayed_rd, delayed_addr directly from registers.
- Reset (rst low, asynchronous):
  - All slot valid, rd and addr are cleared to 0, so delayed_* = 0 and pending_cnt = 0.
  - Combinational outputs evaluate to 0 while rst is low: stall, wb_valid, mem_wait.
  - Reset mid-operation drops all pending loads with no writeback.
- Combinational signals:
  - mem_wait = head.valid & !mem_ready.
  - advance = !mem_wait.
  - wb_valid = head.valid & mem_ready.
- accept = issue_valid & issue_load & advance & !flush.
- On posedge clk when advance = 1:
  - slot0 <= {accept, issue_rd, issue_addr}.
  - slot[i] <= slot[i-1] for i >= 1.
  - If flush = 1, every shifted-in valid is forced to 0, including the slot entering head.
  - rd and addr are captured regardless of valid.
- On posedge clk when advance = 0: all slots hold, issue is ignored, and flush still clears valid of slots 0..LOAD_LAT-2. The head is never flushed, because it is already issued to memory.
- With LOAD_LAT = 1, flush only blocks the current issue.
- Hazard (combinational): set when any candidate below is valid with rd != 0 and matches a used source (rd == dec_rs1 with dec_rs1_used, or rd == dec_rs2 with dec_rs2_used). Candidates:
  - the execute-stage load (issue_valid & issue_load);
  - every valid non-head slot;
  - the head slot, unless FWD = 1 and mem_ready = 1.
- rd = 0 never hazards; such loads are still tracked and presented at head.
- stall = hazard | mem_wait.
- Simultaneous flush and mem_wait: the head holds; younger slots clear.
- Simultaneous wb_valid and a new accept: both occur; pending_cnt is the net popcount of next-state valids.
- pending_cnt is a registered popcount of slot valids.
- No other arithmetic is performed.

Test Plan:
- LOAD_LAT=2, FWD=1: issue load x5 @0x100 at cycle 0 with dec_rs1=5 used, mem_ready=1 → stall high cycles 0–1, low cycle 2. delayed_rd=5, delayed_addr=0x100 and wb_valid=1 in cycle 2. With FWD=0, stall is high cycles 0–2.
- Load to x0 with dec_rs1=0 used → stall never asserts; delayed_load=1 two cycles later.
- Head valid, mem_ready low 3 cycles:
  - stall = mem_wait = 1 for those 3 cycles;
  - delayed_* held constant;
  - a new issue during the wait is not captured;
  - wb_valid pulses 1 cycle when mem_ready rises.
- Back-to-back loads x3 @0x10 and x4 @0x14 → pending_cnt 1 then 2. Head presents x3 then x4 on consecutive cycles. dec_rs2=4 hazards until x4 reaches head.
- flush with one load in slot0 and one at head waiting → slot0 cleared, head retained, pending_cnt=1 next cycle. After mem_ready, wb_valid for the head only.
- rst pulled low asynchronously mid-wait with 2 loads pending → all outputs 0 immediately. After release, no wb_valid until a new load is issued.
